fpu_div: RTL and testbench
==========================

FPU_DIV -- requirements
Module: fpu_div

Interface
REQ-001 The block SHALL have no parameters; the operand format is fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  A and B are valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  32  dividend, binary32.
REQ-007 B  input  32  divisor, binary32.
REQ-008 out_valid  output  1  Z and div_by_zero are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 Z  output  32  quotient A/B, binary32.
REQ-011 div_by_zero  output  1  set with the result when finite nonzero A is divided by zero B.

Function
REQ-012 FSM states SHALL be IDLE, DIVIDE, NORM and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an operand pair is accepted on an edge where in_valid && in_ready, and A/B are captured into internal registers.
REQ-014 On accept with special operands, the FSM SHALL go IDLE->DONE with the special result, so out_valid rises 1 cycle after accept.
REQ-015 On accept with normal operands, the FSM SHALL go to DIVIDE for exactly 25 cycles, then NORM for 1 cycle, then DONE, so out_valid rises 27 cycles after accept.
REQ-016 DIVIDE SHALL run restoring division, one quotient bit per cycle, MSB first: q[24:0] = floor(ma*2^24 / mb), where ma = {1,A[22:0]} and mb = {1,B[22:0]}.
REQ-017 The exponent SHALL be computed signed in at least 10 bits: e = ea - eb + 127 when q[24]=1, else e = ea - eb + 126.
REQ-018 The mantissa SHALL be q[24:1] when q[24]=1, else q[23:0]; the hidden bit is dropped.
REQ-019 Rounding SHALL be truncation (round toward zero); remainder bits are discarded.
REQ-020 The sign SHALL always be A[31] ^ B[31], except that a NaN result is always 0x7FC00000.
REQ-021 If e >= 255, Z SHALL be signed infinity; if e <= 0, Z SHALL be signed zero (flush, no subnormal output).
REQ-022 Subnormal inputs (exponent 0, mantissa nonzero) SHALL be treated as zero.
REQ-023 Special-case priority:
- (1) any NaN input, 0/0 or inf/inf -> 0x7FC00000;
- (2) finite nonzero / zero -> signed inf, div_by_zero=1;
- (3) inf / finite -> signed inf;
- (4) finite / inf, or zero / nonzero -> signed zero.
REQ-024 div_by_zero SHALL be 0 for every other result.
REQ-025 In DONE, out_valid SHALL be 1 and Z and div_by_zero SHALL stay stable until out_ready=1.
REQ-026 On out_valid && out_ready the FSM SHALL return to IDLE; in_ready rises the following cycle, and no accept occurs on the same edge as the pop.
REQ-027 in_valid asserted while not in IDLE SHALL be ignored, with no effect on state.

Reset
REQ-028 While rst=1, the state SHALL be IDLE, out_valid=0, in_ready=1 (asserted the cycle after the rst edge), Z=0 and div_by_zero=0.
REQ-029 rst SHALL take priority over all handshakes.
REQ-030 rst during DIVIDE, NORM or DONE SHALL abort the operation and discard the result; no stale out_valid follows.

Verification
REQ-031 A=0x40C00000, B=0x40000000, out_ready=1 -> Z=0x40400000, div_by_zero=0, out_valid exactly 27 cycles after accept, in_ready=0 throughout.
REQ-032 A=0x3F800000, B=0x40400000 -> Z=0x3EAAAAAA (truncated 1/3); A=0x7F000000, B=0x3E800000 -> Z=0x7F800000; A=0x00800000, B=0x40000000 -> Z=0x00000000.
REQ-033 Specials, each 1 cycle after accept:
- 0x3F800000/0x00000000 -> 0x7F800000, div_by_zero=1;
- 0xBF800000/0x00000000 -> 0xFF800000, div_by_zero=1;
- 0x00000000/0x00000000 -> 0x7FC00000, div_by_zero=0;
- 0x7F800000/0x7F800000 -> 0x7FC00000;
- 0x40000000/0x7F800000 -> 0x00000000.
REQ-034 Backpressure: 6.0/2.0 with out_ready=0 for 5 cycles after out_valid -> Z=0x40400000 held, in_ready=0, in_valid pulses ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-035 Reset mid-op: rst=1 for 1 cycle, 10 cycles into DIVIDE -> out_valid=0, in_ready=1 next cycle; a following 6.0/2.0 yields 0x40400000 at 27 cycles.

Source files
------------

// File: rtl/fpu_div.sv
// rtl/fpu_div.sv - binary32 divider, restoring division, truncating, flush-to-zero
module fpu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Z,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state;
  logic [8:0]  a_hi;      // sign and exponent of the dividend
  logic [31:0] b_reg;     // full divisor, mantissa feeds the divide loop
  logic [24:0] rem;       // partial remainder, always < 2*mb so 25 bits suffice
  logic [24:0] q;         // quotient bits, MSB first
  logic [4:0]  cnt;

  // Operand classification on the input bus, used only at accept time
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic        in_sign;
  logic        is_special;
  logic [31:0] spec_z;
  logic        spec_dbz;

  always_comb begin
    a_nan      = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    a_inf      = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    a_zero     = (A[30:23] == 8'h00);   // subnormals count as zero
    b_nan      = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    b_inf      = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    b_zero     = (B[30:23] == 8'h00);
    in_sign    = A[31] ^ B[31];
    is_special = 1'b1;
    spec_dbz   = 1'b0;
    spec_z     = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_z = 32'h7FC00000;
    end else if (b_zero && !a_inf) begin
      spec_z   = {in_sign, 31'h7F800000};
      spec_dbz = 1'b1;
    end else if (a_inf) begin
      spec_z = {in_sign, 31'h7F800000};
    end else if (b_inf || a_zero) begin
      spec_z = {in_sign, 31'h00000000};
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring-division step: subtract the divisor when it fits
  logic [23:0] mb;
  logic        ge;
  logic [24:0] rem_next;

  always_comb begin
    mb       = {1'b1, b_reg[22:0]};
    ge       = (rem >= {1'b0, mb});
    rem_next = ge ? (rem - {1'b0, mb}) : rem;
  end

  // Exponent/mantissa assembly from the finished quotient, with overflow/underflow clamps
  logic signed [9:0] e_norm;
  logic [22:0]       m_norm;
  logic              n_sign;
  logic [31:0]       z_norm;

  always_comb begin
    n_sign = a_hi[8] ^ b_reg[31];
    e_norm = $signed({2'b00, a_hi[7:0]}) - $signed({2'b00, b_reg[30:23]})
             + (q[24] ? 10'sd127 : 10'sd126);
    m_norm = q[24] ? q[23:1] : q[22:0];
    if (e_norm >= 10'sd255) begin
      z_norm = {n_sign, 31'h7F800000};
    end else if (e_norm <= 10'sd0) begin
      z_norm = {n_sign, 31'h00000000};
    end else begin
      z_norm = {n_sign, e_norm[7:0], m_norm};
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      Z           <= 32'd0;
      div_by_zero <= 1'b0;
      a_hi        <= 9'd0;
      b_reg       <= 32'd0;
      rem         <= 25'd0;
      q           <= 25'd0;
      cnt         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_hi     <= A[31:23];
            b_reg    <= B;
            rem      <= {2'b01, A[22:0]};
            q        <= 25'd0;
            cnt      <= 5'd0;
            in_ready <= 1'b0;
            if (is_special) begin
              Z           <= spec_z;
              div_by_zero <= spec_dbz;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_next << 1;
          q   <= {q[23:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) begin
            state <= NORM;
          end
        end
        NORM: begin
          Z           <= z_norm;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div.sv
// tb/tb_fpu_div.sv - scoreboard bench for fpu_div
module tb_fpu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];
  int          lat_q[$];

  fpu_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference quotient {div_by_zero, Z} and expected accept-to-valid latency
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    logic        s;
    int          ea, eb, e;
    logic [63:0] num, den, qq;
    logic [22:0] m;
    bit an, ai, az, bn, bi, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    lat = 1;
    if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 32'h7FC00000};
    if (bz && !ai) return {1'b1, s, 31'h7F800000};
    if (ai) return {1'b0, s, 31'h7F800000};
    if (bi || az) return {1'b0, s, 31'h00000000};
    lat = 27;
    num = (64'(1) << 23) | 64'(a[22:0]);
    den = (64'(1) << 23) | 64'(b[22:0]);
    qq  = (num << 24) / den;
    if (qq[24]) begin
      e = ea - eb + 127;
      m = qq[23:1];
    end else begin
      e = ea - eb + 126;
      m = qq[22:0];
    end
    if (e >= 255) return {1'b0, s, 31'h7F800000};
    if (e <= 0) return {1'b0, s, 31'h00000000};
    return {1'b0, s, e[7:0], m};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat_exp;
    int          n;
    int          w;
    logic [32:0] want;
    out_ready = (hold == 0);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", in_ready, 1);
    want = ref_div(a, b, lat_exp);
    exp_q.push_back(want);
    lat_q.push_back(lat_exp);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("in_ready_busy", in_ready, 0);
    end while (!out_valid && n < 100);
    check("latency", n, lat_q.pop_front());
    want = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_z", Z, want[31:0]);
      check("hold_in_ready", in_ready, 0);
      A = ~a;
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("z", Z, want[31:0]);
    check("dbz", div_by_zero, want[32]);
    @(negedge clk);
    check("out_valid_after_pop", out_valid, 0);
    check("in_ready_after_pop", in_ready, 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", Z, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 0);
    run_op(32'h3F800000, 32'h40400000, 0);
    run_op(32'h7F000000, 32'h3E800000, 0);
    run_op(32'h00800000, 32'h40000000, 0);
    run_op(32'h3F800000, 32'h00000000, 0);
    run_op(32'hBF800000, 32'h00000000, 0);
    run_op(32'h00000000, 32'h00000000, 0);
    run_op(32'h7F800000, 32'h7F800000, 0);
    run_op(32'h40000000, 32'h7F800000, 0);
    run_op(32'h7FC00001, 32'h3F800000, 0);
    run_op(32'hFF800000, 32'h00000000, 0);
    run_op(32'h00000000, 32'hC0A00000, 0);
    run_op(32'h00400000, 32'h40000000, 0);
    run_op(32'hC0490FDB, 32'h3FB504F3, 0);
    run_op(32'h3FC00000, 32'h3FC00000, 0);

    run_op(32'h40C00000, 32'h40000000, 5);

    for (int i = 0; i < 6; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
      run_op(ra, rb, i % 3);
    end

    // Abort an operation 10 cycles into DIVIDE
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_z", Z, 0);
    stale = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("abort_no_stale", stale, 0);
    run_op(32'h40C00000, 32'h40000000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
